// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: central run/halt/drain sequencer, load-use stall, branch flush and EXE forwarding selects.
// Optional build macro PIPE_STEP_EN adds a single-step input that runs one fetch cycle out of HALT.
module pipe_seq_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef PIPE_STEP_EN
  input  logic             step,
`endif
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_br_taken,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_alusrc,
  input  logic             mem_regwr,
  input  logic [4:0]       mem_rw,
  input  logic             wr_regwr,
  input  logic [4:0]       wr_rw,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_hit;
  logic             lu_bubble;
  logic             start_req;

`ifdef PIPE_STEP_EN
  logic step_q, step_d;
  // Step only launches from HALT; the RUN cycle then drains because run is still low.
  assign step_d    = step;
  assign start_req = run | (step & ~step_q);
`else
  assign start_req = run;
`endif

  // Load in EXE whose destination is a source of the ID instruction.
  assign lu_hit = ex_memread & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (mem_regwr && (mem_rw != 5'd0) && (mem_rw == src)) begin
      sel = 2'd1;
    end else if (wr_regwr && (wr_rw != 5'd0) && (wr_rw == src)) begin
      sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_rs);
    fwd_b = ex_alusrc ? 2'd3 : fwd_sel(ex_rt);
  end

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b1;
    lu_bubble  = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        drain_d = 4'd0;
        if (start_req) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_flush = 1'b0;
        // A pending load-use hides the branch; it is re-resolved after the bubble.
        if (lu_hit) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          lu_bubble  = 1'b1;
        end else if (id_br_taken) begin
          ifid_flush = 1'b1;
        end
        if (!run) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (run) begin
          state_d = ST_RUN;
          drain_d = 4'd0;
        end else if (drain_q <= 4'd1) begin
          state_d = ST_HALT;
          drain_d = 4'd0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_HALT;
        drain_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu_bubble && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ifid_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HALT;
      drain_q     <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef PIPE_STEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end
`endif

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: directed literal checks plus randomized traffic against a rule-level model.
module tb_pipe_seq_ctrl;
  localparam int DC     = 4;
  localparam int CW     = 4;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, run;
  logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, mem_rw, wr_rw;
  logic          id_uses_rt, id_br_taken, ex_memread, ex_alusrc, mem_regwr, wr_regwr;
  logic          pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_seq_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_br_taken(id_br_taken),
    .ex_memread(ex_memread), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_alusrc(ex_alusrc),
    .mem_regwr(mem_regwr), .mem_rw(mem_rw), .wr_regwr(wr_regwr), .wr_rw(wr_rw),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 halted, 1 running, 2 draining with m_left cycles remaining.
  int m_mode, m_left, m_stall, m_flush;
  bit m_lu, m_br;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_model(input bit mw, input int mr, input bit ww, input int wr, input int src);
    if (mw && mr != 0 && mr == src) return 1;
    if (ww && wr != 0 && wr == src) return 2;
    return 0;
  endfunction

  task automatic compare_all();
    bit running;
    running = (m_mode == 1);
    m_lu = running && ex_memread && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    m_br = running && id_br_taken && !m_lu;
    chk("state",      int'(state),      m_mode);
    chk("pc_en",      int'(pc_en),      int'(running && !m_lu));
    chk("ifid_en",    int'(ifid_en),    int'(running && !m_lu));
    chk("ifid_flush", int'(ifid_flush), int'(m_br));
    chk("idex_flush", int'(idex_flush), int'(!running || m_lu));
    chk("fwd_a",      int'(fwd_a),      fwd_model(mem_regwr, mem_rw, wr_regwr, wr_rw, ex_rs));
    chk("fwd_b",      int'(fwd_b),      ex_alusrc ? 3 : fwd_model(mem_regwr, mem_rw, wr_regwr, wr_rw, ex_rt));
    chk("stall_cnt",  int'(stall_cnt),  m_stall);
    chk("flush_cnt",  int'(flush_cnt),  m_flush);
  endtask

  task automatic model_advance();
    if (m_lu && m_stall < SATMAX) m_stall++;
    if (m_br && m_flush < SATMAX) m_flush++;
    case (m_mode)
      0: if (run) m_mode = 1;
      1: if (!run) begin m_mode = 2; m_left = DC; end
      default: begin
        if (run) m_mode = 1;
        else if (m_left == 1) m_mode = 0;
        else m_left--;
      end
    endcase
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    compare_all();
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_br_taken = 0;
    ex_memread = 0; ex_rs = 0; ex_rt = 0; ex_alusrc = 0;
    mem_regwr = 0; mem_rw = 0; wr_regwr = 0; wr_rw = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_pc_en", int'(pc_en), 0);
    chk("rst_idex_flush", int'(idex_flush), 1);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lu();
    ex_memread = 1; ex_rt = 8; id_rs = 8;
  endtask

  bit run_r;

  initial begin
    rst = 1'b1; run = 1'b0;
    clear_inputs();
    m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    do_reset();
    tick();

    // Start: RUN one edge after run rises, fetch enabled in that RUN cycle.
    run = 1'b1;
    #1 chk("halt_pc_en", int'(pc_en), 0);
    tick();
    #1 chk("start_state", int'(state), 1);
    chk("start_pc_en", int'(pc_en), 1);
    tick();

    // Load-use bubble for exactly one cycle.
    set_lu();
    #1 chk("lu_pc_en", int'(pc_en), 0);
    chk("lu_ifid_en", int'(ifid_en), 0);
    chk("lu_idex_flush", int'(idex_flush), 1);
    tick();
    ex_memread = 0;
    #1 chk("lu_stall_cnt", int'(stall_cnt), 1);
    chk("lu_clear_pc_en", int'(pc_en), 1);
    tick();

    // Taken branch flushes IF/ID; load-use masks it.
    clear_inputs();
    id_br_taken = 1;
    #1 chk("br_ifid_flush", int'(ifid_flush), 1);
    chk("br_pc_en", int'(pc_en), 1);
    tick();
    #1 chk("br_flush_cnt", int'(flush_cnt), 1);
    set_lu();
    #1 chk("br_lu_ifid_flush", int'(ifid_flush), 0);
    chk("br_lu_pc_en", int'(pc_en), 0);
    tick();
    #1 chk("br_lu_flush_cnt", int'(flush_cnt), 1);
    chk("br_lu_stall_cnt", int'(stall_cnt), 2);
    clear_inputs();

    // Forwarding priority.
    mem_regwr = 1; mem_rw = 5; wr_regwr = 1; wr_rw = 5; ex_rs = 5;
    #1 chk("fwd_a_mem", int'(fwd_a), 1);
    mem_regwr = 0;
    #1 chk("fwd_a_wr", int'(fwd_a), 2);
    ex_rs = 0;
    #1 chk("fwd_a_r0", int'(fwd_a), 0);
    ex_alusrc = 1;
    #1 chk("fwd_b_imm", int'(fwd_b), 3);
    tick();
    clear_inputs();

    // Drain: DC cycles in DRAIN, then HALT.
    run = 1'b0;
    tick();
    for (int i = 0; i < DC; i++) begin
      #1 chk("drain_state", int'(state), 2);
      tick();
    end
    #1 chk("drain_done_state", int'(state), 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    run = 1'b1;
    #1 chk("drain2_state", int'(state), 2);
    tick();
    #1 chk("resume_state", int'(state), 1);

    // Saturation of the stall counter.
    set_lu();
    for (int i = 0; i < 20; i++) tick();
    chk("stall_sat", int'(stall_cnt), SATMAX);

    // Reset mid-stall, then mid-drain.
    do_reset();
    tick();
    tick();
    set_lu();
    tick();
    do_reset();
    clear_inputs();
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    do_reset();

    // Randomized traffic.
    run_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 6) run_r = ~run_r;
      run         = run_r;
      id_rs       = 5'($urandom_range(0, 7));
      id_rt       = 5'($urandom_range(0, 7));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_br_taken = ($urandom_range(0, 99) < 25);
      ex_memread  = ($urandom_range(0, 99) < 35);
      ex_rs       = 5'($urandom_range(0, 7));
      ex_rt       = 5'($urandom_range(0, 7));
      ex_alusrc   = ($urandom_range(0, 99) < 20);
      mem_regwr   = 1'($urandom_range(0, 1));
      mem_rw      = 5'($urandom_range(0, 7));
      wr_regwr    = 1'($urandom_range(0, 1));
      wr_rw       = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 999) < 3) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
